// File: rtl/pll_lock_rst_gen.sv
// PLL lock qualifier: holds downstream reset until lock is stable.
// Ports: sys_clk/sys_rst in; pll_locked async in;
//   rst_out/rst_out_n, lock_ready, lock_lost pulse, lock_loss_cnt out.
// Optional: PLL_LOCK_LOSS_CNT_EN enables the saturating loss counter;
//   when undefined, lock_loss_cnt is tied to zero.
module pll_lock_rst_gen #(
  parameter int STABLE_CYC = 1000,
  parameter int HOLD_CYC   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pll_locked,
  output logic             rst_out,
  output logic             rst_out_n,
  output logic             lock_ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_CYC =
    (STABLE_CYC > HOLD_CYC) ? STABLE_CYC : HOLD_CYC;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] STABLE_LAST =
    CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          lost_nxt;
  logic          sync_q;
  logic          locked_s;

  // Only the first flop ever sees the raw lock signal.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Loss of lock takes priority over the terminal count,
  // so a drop on the last qualifying cycle still restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    lost_nxt  = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s)
          state_nxt = STABLE;
      end
      STABLE: begin
        if (!locked_s)
          state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)
          state_nxt = HOLD;
        else
          cnt_nxt = cnt + CW'(1);
      end
      HOLD: begin
        if (!locked_s)
          state_nxt = WAIT_LOCK;
        else if (cnt == HOLD_LAST)
          state_nxt = RUN;
        else
          cnt_nxt = cnt + CW'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          lost_nxt  = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_out    <= 1'b1;
      rst_out_n  <= 1'b0;
      lock_ready <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rst_out    <= (state_nxt != RUN);
      rst_out_n  <= (state_nxt == RUN);
      lock_ready <= (state_nxt == RUN);
      lock_lost  <= lost_nxt;
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  // Steps on the same edge that raises lock_lost.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      lock_loss_cnt <= '0;
    else if (lost_nxt && (lock_loss_cnt != '1))
      lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Directed bench for pll_lock_rst_gen.
// STABLE_CYC=8, HOLD_CYC=4, CNT_W=2: release takes 15 edges.
module tb_pll_lock_rst_gen;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk;
  logic       sys_rst;
  logic       pll_locked;
  logic       rst_out;
  logic       rst_out_n;
  logic       lock_ready;
  logic       lock_lost;
  logic [1:0] lock_loss_cnt;

  int checks = 0;
  int passed = 0;

  pll_lock_rst_gen #(
    .STABLE_CYC(8),
    .HOLD_CYC  (4),
    .CNT_W     (2)
  ) dut (
    .sys_clk      (clk),
    .sys_rst      (sys_rst),
    .pll_locked   (pll_locked),
    .rst_out      (rst_out),
    .rst_out_n    (rst_out_n),
    .lock_ready   (lock_ready),
    .lock_lost    (lock_lost),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after "edge 0" with reset released.
  task automatic reset_dut(input logic lk);
    sys_rst    = 1'b1;
    pll_locked = lk;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst    = 1'b1;
    pll_locked = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({rst_out, rst_out_n, lock_ready, lock_lost,
         lock_loss_cnt} !== 6'b100000)
      $display("FAIL reset_vals: got %b want 100000",
               {rst_out, rst_out_n, lock_ready, lock_lost,
                lock_loss_cnt});
    else passed++;
    sys_rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++;
      if ({rst_out, lock_ready} !== 2'b10)
        $display("FAIL reset_hold e%0d: got %b want 10",
                 e, {rst_out, lock_ready});
      else passed++;
    end
    step();
    checks++;
    if ({rst_out, rst_out_n, lock_ready, lock_lost}
        !== 4'b0110)
      $display("FAIL reset_release e15: got %b want 0110",
               {rst_out, rst_out_n, lock_ready, lock_lost});
    else passed++;
  endtask

  task automatic test_stable_loss();
    reset_dut(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 6; e++) step();
    pll_locked = 1'b0;
    for (int e = 7; e <= 9; e++) step();
    pll_locked = 1'b1;
    for (int e = 10; e <= 23; e++) begin
      step();
      checks++;
      if ({rst_out, lock_lost} !== 2'b10)
        $display("FAIL stable_loss e%0d: got %b want 10",
                 e, {rst_out, lock_lost});
      else passed++;
    end
    step();
    checks++;
    if ({rst_out, lock_ready, lock_loss_cnt} !== 4'b0100)
      $display("FAIL stable_requal e24: got %b want 0100",
               {rst_out, lock_ready, lock_loss_cnt});
    else passed++;
  endtask

  task automatic test_hold_loss();
    reset_dut(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 11; e++) step();
    pll_locked = 1'b0;
    for (int e = 12; e <= 14; e++) step();
    pll_locked = 1'b1;
    for (int e = 15; e <= 28; e++) begin
      step();
      checks++;
      if ({rst_out, lock_lost} !== 2'b10)
        $display("FAIL hold_loss e%0d: got %b want 10",
                 e, {rst_out, lock_lost});
      else passed++;
    end
    step();
    checks++;
    if ({rst_out, lock_ready, lock_loss_cnt} !== 4'b0100)
      $display("FAIL hold_requal e29: got %b want 0100",
               {rst_out, lock_ready, lock_loss_cnt});
    else passed++;
  endtask

  task automatic test_run_loss();
    logic [1:0] exp_cnt;
    exp_cnt = (CNT_ON != 0) ? 2'd1 : 2'd0;
    reset_dut(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 17; e++) step();
    pll_locked = 1'b0;
    for (int e = 18; e <= 19; e++) begin
      step();
      checks++;
      if ({rst_out, lock_lost} !== 2'b00)
        $display("FAIL run_pre_loss e%0d: got %b want 00",
                 e, {rst_out, lock_lost});
      else passed++;
    end
    pll_locked = 1'b1;
    step();
    checks++;
    if ({rst_out, rst_out_n, lock_ready, lock_lost}
        !== 4'b1001)
      $display("FAIL run_loss e20: got %b want 1001",
               {rst_out, rst_out_n, lock_ready, lock_lost});
    else passed++;
    checks++;
    if (lock_loss_cnt !== exp_cnt)
      $display("FAIL run_loss_cnt: got %0d want %0d",
               lock_loss_cnt, exp_cnt);
    else passed++;
    for (int e = 21; e <= 33; e++) begin
      step();
      checks++;
      if ({rst_out, lock_lost} !== 2'b10)
        $display("FAIL run_requal e%0d: got %b want 10",
                 e, {rst_out, lock_lost});
      else passed++;
    end
    step();
    checks++;
    if ({rst_out, lock_ready} !== 2'b01)
      $display("FAIL run_requal e34: got %b want 01",
               {rst_out, lock_ready});
    else passed++;
    checks++;
    if (lock_loss_cnt !== exp_cnt)
      $display("FAIL run_cnt_keep: got %0d want %0d",
               lock_loss_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_saturate();
    int         pulses;
    logic [1:0] exp_cnt;
    pulses = 0;
    reset_dut(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 15; e++) step();
    for (int i = 0; i < 5; i++) begin
      pll_locked = 1'b0;
      step();
      step();
      pll_locked = 1'b1;
      for (int k = 0; k < 18; k++) begin
        step();
        if (lock_lost === 1'b1) pulses++;
      end
      exp_cnt = (CNT_ON != 0) ?
        2'((i + 1 > 3) ? 3 : i + 1) : 2'd0;
      checks++;
      if ({lock_ready, lock_loss_cnt} !== {1'b1, exp_cnt})
        $display("FAIL sat_loop%0d: got %b want %b",
                 i, {lock_ready, lock_loss_cnt},
                 {1'b1, exp_cnt});
      else passed++;
    end
    checks++;
    if (pulses !== 5)
      $display("FAIL sat_pulses: got %0d want 5", pulses);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [1:0] exp_cnt;
    exp_cnt = (CNT_ON != 0) ? 2'd1 : 2'd0;
    reset_dut(1'b0);
    pll_locked = 1'b1;
    for (int e = 1; e <= 13; e++) step();
    #3 sys_rst = 1'b1;
    #1;
    checks++;
    if ({rst_out, rst_out_n, lock_ready, lock_lost,
         lock_loss_cnt} !== 6'b100000)
      $display("FAIL arst_hold: got %b want 100000",
               {rst_out, rst_out_n, lock_ready, lock_lost,
                lock_loss_cnt});
    else passed++;
    step();
    sys_rst = 1'b0;
    for (int e = 1; e <= 14; e++) step();
    checks++;
    if (rst_out !== 1'b1)
      $display("FAIL arst_hold_e14: got %b want 1", rst_out);
    else passed++;
    step();
    checks++;
    if ({rst_out, lock_ready} !== 2'b01)
      $display("FAIL arst_hold_e15: got %b want 01",
               {rst_out, lock_ready});
    else passed++;
    pll_locked = 1'b0;
    step();
    step();
    pll_locked = 1'b1;
    for (int k = 0; k < 18; k++) step();
    checks++;
    if ({lock_ready, lock_loss_cnt} !== {1'b1, exp_cnt})
      $display("FAIL arst_pre_run: got %b want %b",
               {lock_ready, lock_loss_cnt}, {1'b1, exp_cnt});
    else passed++;
    #3 sys_rst = 1'b1;
    #1;
    checks++;
    if ({rst_out, rst_out_n, lock_ready, lock_lost,
         lock_loss_cnt} !== 6'b100000)
      $display("FAIL arst_run: got %b want 100000",
               {rst_out, rst_out_n, lock_ready, lock_lost,
                lock_loss_cnt});
    else passed++;
    step();
    sys_rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++;
      if (rst_out !== 1'b1)
        $display("FAIL arst_run_requal e%0d: got %b want 1",
                 e, rst_out);
      else passed++;
    end
    step();
    checks++;
    if ({rst_out, rst_out_n, lock_ready} !== 3'b011)
      $display("FAIL arst_run_e15: got %b want 011",
               {rst_out, rst_out_n, lock_ready});
    else passed++;
  endtask

  initial begin
    sys_rst    = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_stable_loss();
    test_hold_loss();
    test_run_loss();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_rst_gen.md
PLL_LOCK_RST_GEN -- requirements
Module: pll_lock_rst_gen

Interface
REQ-001 Parameter STABLE_CYC, 1000: cycles pll_locked must stay high before hold phase; legal range 1..65535.
REQ-002 Parameter HOLD_CYC, 16: extra cycles rst_out stays asserted after stability qualified; legal range 1..65535.
REQ-003 Parameter CNT_W, 8: width of lock_loss_cnt.
REQ-004 sys_clk  input  1  free-running reference clock (same clock that feeds the PLL); all logic on its rising edge.
REQ-005 sys_rst  input  1  asynchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock indicator, asynchronous to sys_clk.
REQ-007 rst_out  output  1  active-high reset for logic downstream of the PLL.
REQ-008 rst_out_n  output  1  logical inverse of rst_out.
REQ-009 lock_ready  output  1  high only in state RUN.
REQ-010 lock_lost  output  1  single-cycle pulse on loss of lock while in RUN.
REQ-011 lock_loss_cnt  output  CNT_W  number of lock_lost pulses since reset, saturating.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer to locked_s; no other logic samples pll_locked.
REQ-013 FSM states SHALL be WAIT_LOCK, STABLE, HOLD, RUN, with one shared cycle counter of width ceil(log2(max(STABLE_CYC,HOLD_CYC)))+1.
REQ-014 WAIT_LOCK: counter held 0; locked_s=1 -> STABLE.
REQ-015 STABLE: counter increments each cycle; locked_s=0 -> WAIT_LOCK, counter cleared; counter = STABLE_CYC-1 with locked_s=1 -> HOLD, counter cleared.
REQ-016 HOLD: counter increments; locked_s=0 -> WAIT_LOCK; counter = HOLD_CYC-1 with locked_s=1 -> RUN.
REQ-017 RUN: locked_s=0 -> WAIT_LOCK and lock_lost=1 for exactly that transition cycle.
REQ-018 All outputs SHALL be registered, decoded from next-state: rst_out=0 and lock_ready=1 exactly while state is RUN; rst_out=1 otherwise.
REQ-019 With pll_locked rising between edges 0 and 1 and held high, rst_out SHALL fall at edge 3+STABLE_CYC+HOLD_CYC.
REQ-020 After lock loss in RUN, rst_out SHALL be 1 from the edge that registers the loss (2 edges after pll_locked falls, plus 1).
REQ-021 Loss of lock in STABLE or HOLD SHALL restart qualification without lock_lost pulse or count increment.
REQ-022 lock_loss_cnt SHALL increment by 1 on each lock_lost pulse and saturate at 2^CNT_W-1.
REQ-023 Glitch of pll_locked shorter than one cycle that is not captured by the synchronizer SHALL have no effect; a captured glitch is treated as a real loss.

Reset
REQ-024 sys_rst=1 SHALL asynchronously force: synchronizer flops 0, state WAIT_LOCK, counter 0, rst_out=1, rst_out_n=0, lock_ready=0, lock_lost=0, lock_loss_cnt=0.
REQ-025 After sys_rst deasserts, full qualification (REQ-019) SHALL be required even if pll_locked is already high; rst_out deasserts only synchronously.
REQ-026 sys_rst asserted mid-qualification or in RUN SHALL abort immediately to reset values.

Configuration
REQ-027 Macro PLL_LOCK_LOSS_CNT_EN: defined -> lock_loss_cnt counter implemented per REQ-022; undefined -> counter logic absent, lock_loss_cnt tied to 0; lock_lost pulse present in both cases.

Verification (STABLE_CYC=8, HOLD_CYC=4, CNT_W=2)
REQ-028 Reset, pll_locked=1 set before edge 1 and held -> rst_out=1 through edge 14, rst_out=0 / lock_ready=1 at edge 15.
REQ-029 pll_locked low for 3 cycles at edge 6 of STABLE -> no lock_lost, lock_loss_cnt=0, rst_out falls 15 edges after re-rise.
REQ-030 In RUN, pll_locked low 2 cycles -> one lock_lost pulse, rst_out=1 within 3 edges, lock_loss_cnt=1, re-qualification 15 edges after re-rise.
REQ-031 Five lock losses from RUN -> lock_loss_cnt=3 (saturated); without PLL_LOCK_LOSS_CNT_EN -> lock_loss_cnt=0, five lock_lost pulses.
REQ-032 sys_rst pulsed during HOLD and during RUN -> outputs at reset values asynchronously, full 15-edge qualification after release.
